// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
//
// Purpose: groups every pipeline-facing signal of the bimodal branch predictor
// into one bundle. The pipeline owns the master side and the predictor owns
// the slave side.
//
// Signal summary:
//   pc_f            master->slave  XLEN   PC of the instruction in IF
//   is_branch_f     master->slave  1      IF instruction is a conditional branch
//   stall_if_id     master->slave  1      hold the IF/ID stage
//   flush_if_id     master->slave  1      squash the IF/ID stage (beats stall)
//   resolve_valid   master->slave  1      branch in ID resolves this cycle
//   branch_actual   master->slave  1      resolved direction, 1 = taken
//   branch_predict  slave->master  1      registered prediction for ID
//   predict_taken_f slave->master  1      combinational prediction for IF
//   mispredict      slave->master  1      qualified resolve disagreed with prediction
//   branch_cnt      slave->master  CNT_W  saturating count of resolved branches
//   mispredict_cnt  slave->master  CNT_W  saturating count of mispredicts
//
// Handshake: resolve_valid is a one-way valid strobe with no ready. The
// predictor always accepts it, and it takes effect at the next clk edge only
// when a branch is actually held in ID. branch_actual is meaningful only while
// resolve_valid is high.
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
);
    logic [XLEN-1:0]  pc_f;
    logic             is_branch_f;
    logic             stall_if_id;
    logic             flush_if_id;
    logic             resolve_valid;
    logic             branch_actual;
    logic             branch_predict;
    logic             predict_taken_f;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispredict_cnt;

    modport master (
        output pc_f, is_branch_f, stall_if_id, flush_if_id,
               resolve_valid, branch_actual,
        input  branch_predict, predict_taken_f, mispredict,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_f, is_branch_f, stall_if_id, flush_if_id,
               resolve_valid, branch_actual,
        output branch_predict, predict_taken_f, mispredict,
               branch_cnt, mispredict_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Purpose: bimodal predictor made of BHT_ENTRIES 2-bit saturating counters,
// indexed by pc_f[IDX_W+1:2]. The lookup happens in IF. The prediction and the
// index used for it are carried through the IF/ID register. When the branch
// resolves in ID, that counter is trained and the performance counters are
// stepped.
//
// Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
// The prediction is bit [1] of the counter.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset; it dominates every other input
//   bp   branch_predictor_if.slave (see the interface for the signal list)
// ---------------------------------------------------------------------------
module branch_predictor #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64,
    parameter int CNT_W       = 32
) (
    input logic clk,
    input logic rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] idx_f;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             pred_q, pred_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    logic             update_en;
    logic [1:0]       ctr_old;
    logic [1:0]       ctr_new;
    logic [1:0]       ctr_f;
    logic             mispredict_w;

    // PC bits outside the index field do not affect the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.pc_f[XLEN-1:IDX_W+2], bp.pc_f[1:0]};

    assign idx_f = bp.pc_f[IDX_W+1:2];

    // Training and lookup
    always_comb begin
        // A resolve only counts when a branch is actually held in ID.
        // Gating with rst keeps mispredict low and blocks any update
        // during reset cycles.
        update_en = !rst && bp.resolve_valid && valid_q;

        ctr_old = bht_q[idx_q];
        ctr_new = ctr_old;
        if (bp.branch_actual) begin
            if (ctr_old != 2'b11) ctr_new = ctr_old + 2'b01;
        end else begin
            if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
        end

        // Write bypass: an IF lookup that hits the entry being trained this
        // cycle sees the post-update value.
        if (update_en && (idx_q == idx_f)) ctr_f = ctr_new;
        else                               ctr_f = bht_q[idx_f];

        mispredict_w = update_en && (bp.branch_actual != pred_q);
    end

    // IF/ID register next state and performance counters
    always_comb begin
        pred_d  = pred_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        if (bp.flush_if_id) begin
            pred_d  = 1'b0;
            valid_d = 1'b0;
        end else if (!bp.stall_if_id) begin
            pred_d  = bp.is_branch_f && ctr_f[1];
            idx_d   = idx_f;
            valid_d = bp.is_branch_f;
        end

        // Both counters saturate at all-ones instead of wrapping.
        bcnt_d = bcnt_q;
        mcnt_d = mcnt_q;
        if (update_en && !(&bcnt_q))                 bcnt_d = bcnt_q + CNT_ONE;
        if (mispredict_w && !(&mcnt_q))              mcnt_d = mcnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
            pred_q  <= 1'b0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            bcnt_q  <= '0;
            mcnt_q  <= '0;
        end else begin
            if (update_en) bht_q[idx_q] <= ctr_new;
            pred_q  <= pred_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            bcnt_q  <= bcnt_d;
            mcnt_q  <= mcnt_d;
        end
    end

    assign bp.predict_taken_f = bp.is_branch_f && ctr_f[1];
    assign bp.branch_predict  = pred_q;
    assign bp.mispredict      = mispredict_w;
    assign bp.branch_cnt      = bcnt_q;
    assign bp.mispredict_cnt  = mcnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
    localparam int XLEN = 32;
    localparam int BHT  = 64;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk;
    logic rst;

    branch_predictor_if #(.XLEN(XLEN), .CNT_W(CNTW)) bp_bus ();

    branch_predictor #(.XLEN(XLEN), .BHT_ENTRIES(BHT), .CNT_W(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bp_bus.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: counter strength 0..3 per entry, plain integers
    int   m_bht [BHT];
    logic m_pred;
    int   m_idx;
    logic m_valid;
    int   m_bcnt;
    int   m_mcnt;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies one cycle of inputs, checks outputs against the model before the
    // edge, then advances the model across the edge. dir_ptf >= 0 adds a
    // directed expectation for predict_taken_f.
    task automatic cycle(input string tag, input logic r, input logic [31:0] pc,
                         input logic br, input logic st, input logic fl,
                         input logic rv, input logic act, input int dir_ptf);
        int   after [BHT];
        int   idx_in;
        logic upd;
        logic exp_pt;
        logic exp_mis;

        rst                  = r;
        bp_bus.pc_f          = pc;
        bp_bus.is_branch_f   = br;
        bp_bus.stall_if_id   = st;
        bp_bus.flush_if_id   = fl;
        bp_bus.resolve_valid = rv;
        bp_bus.branch_actual = act;
        #1;

        idx_in = int'((pc >> 2) % BHT);
        upd    = !r && rv && m_valid;
        after  = m_bht;
        if (upd) begin
            if (act) after[m_idx] = (after[m_idx] == 3) ? 3 : after[m_idx] + 1;
            else     after[m_idx] = (after[m_idx] == 0) ? 0 : after[m_idx] - 1;
        end
        exp_pt  = br && (after[idx_in] >= 2);
        exp_mis = upd && (act != m_pred);

        if (!r) chk({tag, "_ptf"}, 32'(bp_bus.predict_taken_f), 32'(exp_pt));
        if (dir_ptf >= 0) chk({tag, "_ptf_dir"}, 32'(bp_bus.predict_taken_f), 32'(dir_ptf));
        chk({tag, "_mis"},  32'(bp_bus.mispredict),     32'(exp_mis));
        chk({tag, "_bp"},   32'(bp_bus.branch_predict), 32'(m_pred));
        chk({tag, "_bcnt"}, 32'(bp_bus.branch_cnt),     32'(m_bcnt));
        chk({tag, "_mcnt"}, 32'(bp_bus.mispredict_cnt), 32'(m_mcnt));

        @(posedge clk);
        if (r) begin
            for (int i = 0; i < BHT; i++) m_bht[i] = 1;
            m_pred  = 1'b0;
            m_idx   = 0;
            m_valid = 1'b0;
            m_bcnt  = 0;
            m_mcnt  = 0;
        end else begin
            m_bht = after;
            if (upd) begin
                if (m_bcnt < CMAX) m_bcnt++;
                if (exp_mis && m_mcnt < CMAX) m_mcnt++;
            end
            if (fl) begin
                m_pred  = 1'b0;
                m_valid = 1'b0;
            end else if (!st) begin
                m_pred  = exp_pt;
                m_idx   = idx_in;
                m_valid = br;
            end
        end
        #1;
    endtask

    // Shorthands: a branch lookup in IF with nothing resolving, and a
    // resolve in ID with a non-branch in IF.
    task automatic lookup(input string tag, input logic [31:0] pc, input int dir_ptf);
        cycle(tag, 1'b0, pc, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, dir_ptf);
    endtask

    task automatic resolve(input string tag, input logic act);
        cycle(tag, 1'b0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, act, -1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int i = 0; i < BHT; i++) m_bht[i] = 1;
        m_pred  = 1'b0;
        m_idx   = 0;
        m_valid = 1'b0;
        m_bcnt  = 0;
        m_mcnt  = 0;

        rst                  = 1'b1;
        bp_bus.pc_f          = '0;
        bp_bus.is_branch_f   = 1'b0;
        bp_bus.stall_if_id   = 1'b0;
        bp_bus.flush_if_id   = 1'b0;
        bp_bus.resolve_valid = 1'b0;
        bp_bus.branch_actual = 1'b0;
        @(posedge clk);
        #1;

        cycle("rst0", 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        cycle("rst1", 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        chk("rst_bp", 32'(bp_bus.branch_predict), 32'd0);

        // Reset lookup, then train 0x100 toward strong-taken
        lookup("lk100_a", 32'h100, 0);
        chk("lk100_a_reg", 32'(bp_bus.branch_predict), 32'd0);
        resolve("res_t1", 1'b1);
        lookup("lk100_b", 32'h100, 1);
        resolve("res_t2", 1'b1);
        lookup("lk100_c", 32'h100, 1);
        resolve("res_t3", 1'b1);
        chk("cnt_b3", 32'(bp_bus.branch_cnt), 32'd3);
        chk("cnt_m1", 32'(bp_bus.mispredict_cnt), 32'd1);

        // Walk back down: strong-T -> weak-T (still taken) -> weak-NT
        lookup("lk100_d", 32'h100, 1);
        resolve("res_n1", 1'b0);
        lookup("lk100_e", 32'h100, 1);
        resolve("res_n2", 1'b0);
        lookup("lk100_f", 32'h100, 0);
        cycle("idle0", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Stall holds the IF/ID state; flush with stall squashes it
        lookup("lk104_a", 32'h104, 0);
        resolve("res104", 1'b1);
        lookup("lk104_b", 32'h104, 1);
        for (int i = 0; i < 3; i++)
            cycle("stall", 1'b0, 32'h300 + 32'(i * 4), 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
        chk("stall_hold", 32'(bp_bus.branch_predict), 32'd1);
        cycle("flush", 1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, -1);
        chk("flush_bp", 32'(bp_bus.branch_predict), 32'd0);
        resolve("res_squash", 1'b0);
        chk("squash_cnt", 32'(bp_bus.branch_cnt), 32'd6);
        lookup("lk104_c", 32'h104, 1);
        cycle("idle1", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Bypass on an aliased PC: 0x014 and 0x114 share idx 5
        lookup("lk014", 32'h014, 0);
        cycle("bypass", 1'b0, 32'h114, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1);
        lookup("lk014_b", 32'h014, 1);
        cycle("idle2", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);

        // Alternate outcomes at idx 7 so every resolve mispredicts
        for (int i = 0; i < 16; i++) begin
            lookup("sat_lk", 32'h01C, -1);
            resolve("sat_res", (i % 2) == 0);
        end
        chk("sat_m15", 32'(bp_bus.mispredict_cnt), 32'd15);
        chk("sat_b15", 32'(bp_bus.branch_cnt), 32'd15);

        // Reset in the middle of an in-flight prediction and resolve
        lookup("pre_rst", 32'h104, 1);
        cycle("mid_rst", 1'b1, 32'h104, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, -1);
        chk("mrst_bp", 32'(bp_bus.branch_predict), 32'd0);
        chk("mrst_b",  32'(bp_bus.branch_cnt), 32'd0);
        chk("mrst_m",  32'(bp_bus.mispredict_cnt), 32'd0);
        for (int i = 0; i < BHT; i++) lookup("post_rst", 32'(i * 4), 0);

        // Randomized traffic with aliasing PCs and occasional resets
        for (int i = 0; i < 3000; i++) begin
            cycle("rnd",
                  $urandom_range(0, 199) == 0,
                  32'($urandom_range(0, 2 * BHT - 1) * 4 + $urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) != 0,
                  -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
